// File: rtl/dot_product_sequencer_pkg.sv
// Shared NPU constants and the dot-product sequencer state encoding.
package dot_product_sequencer_pkg;

    localparam int NPU_MAX_MACS          = 64;  // lanes per MAC-array beat
    localparam int NPU_DATA_WIDTH        = 8;   // signed operand width
    localparam int NPU_MAX_GROUPS        = 8;   // group fields on num_macs / mac_out
    localparam int NPU_MAC_BIT_PER_GROUP = 6;   // per-group lane-count field width
    localparam int NPU_GROUP_LANES       = 32;  // lanes per MAC group
    localparam int NPU_RES_WIDTH         = 32;  // per-group result width
    localparam int NPU_MAC_LATENCY       = 2;   // mac_valid_in -> mac_valid_out
    localparam int NPU_GROUPS_USED       = 2;   // each 64-lane chunk is two groups

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/lane_mask_gen.sv
// Lane-enable mask and per-group lane counts for a chunk with `rem` elements left.
module lane_mask_gen
    import dot_product_sequencer_pkg::*;
#(
    parameter int MAX_MACS          = NPU_MAX_MACS,
    parameter int LEN_WIDTH         = 16,
    parameter int MAC_BIT_PER_GROUP = NPU_MAC_BIT_PER_GROUP,
    parameter int GROUP_LANES       = NPU_GROUP_LANES
) (
    input  logic [LEN_WIDTH-1:0]         rem,
    output logic [MAX_MACS-1:0]          lane_mask,
    output logic [MAC_BIT_PER_GROUP-1:0] g0_cnt,
    output logic [MAC_BIT_PER_GROUP-1:0] g1_cnt
);

    localparam logic [LEN_WIDTH-1:0] GL = LEN_WIDTH'(GROUP_LANES);

    logic [LEN_WIDTH-1:0] g0_full, g1_full, rem_g1;

    // A lane is live when its index is below the remaining element count.
    for (genvar i = 0; i < MAX_MACS; i++) begin : g_lane
        assign lane_mask[i] = (rem > LEN_WIDTH'(i));
    end

    // Group 0 takes up to a full group first, group 1 gets what is left.
    always_comb begin
        g0_full = (rem >= GL) ? GL : rem;
        rem_g1  = rem - g0_full;
        g1_full = (rem_g1 >= GL) ? GL : rem_g1;
        g0_cnt  = g0_full[MAC_BIT_PER_GROUP-1:0];
        g1_cnt  = g1_full[MAC_BIT_PER_GROUP-1:0];
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams a vector from the operand buffer through the MAC array one 64-lane
// chunk per cycle and accumulates the two group sums into one 32-bit result.
module dot_product_sequencer
    import dot_product_sequencer_pkg::*;
#(
    parameter int MAX_MACS          = NPU_MAX_MACS,
    parameter int DATA_WIDTH        = NPU_DATA_WIDTH,
    parameter int MAC_BIT_PER_GROUP = NPU_MAC_BIT_PER_GROUP,
    parameter int MAX_GROUPS        = NPU_MAX_GROUPS,
    parameter int LEN_WIDTH         = 16,
    parameter int ADDR_WIDTH        = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [LEN_WIDTH-1:0]                  vec_len,
    input  logic [ADDR_WIDTH-1:0]                 base_addr,
    output logic                                  busy,
    output logic                                  rd_en,
    output logic [ADDR_WIDTH-1:0]                 rd_addr,
    input  logic [MAX_MACS*DATA_WIDTH-1:0]        rd_data,
    input  logic [MAX_MACS*DATA_WIDTH-1:0]        rd_weight,
    output logic                                  mac_valid_in,
    output logic [3:0]                            mac_num_groups,
    output logic [MAX_GROUPS*MAC_BIT_PER_GROUP-1:0] mac_num_macs,
    output logic [MAX_MACS*DATA_WIDTH-1:0]        mac_data,
    output logic [MAX_MACS*DATA_WIDTH-1:0]        mac_weight,
    input  logic [MAX_GROUPS*NPU_RES_WIDTH-1:0]   mac_out,
    input  logic                                  mac_valid_out,
    output logic signed [NPU_RES_WIDTH-1:0]       res_data,
    output logic                                  res_valid,
    input  logic                                  res_ready
);

    localparam int RW         = NPU_RES_WIDTH;
    localparam int STAGES     = NPU_MAC_LATENCY;
    localparam int LANE_SHIFT = $clog2(MAX_MACS);
    localparam logic [LEN_WIDTH-1:0] CHUNK_ELEMS = LEN_WIDTH'(MAX_MACS);
    localparam logic [LEN_WIDTH-1:0] ONE         = LEN_WIDTH'(1);

    seq_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [LEN_WIDTH-1:0]    chunks_q, issue_cnt_q, res_cnt_q, issue_rem_q, mac_rem_q;
    logic signed [RW-1:0]    acc_q;
    // vld_pipe[0] is the MAC issue beat; vld_pipe[STAGES] lines up with its result.
    logic [STAGES:0]         vld_pipe;
    logic                    accept, res_take, last_issue, last_result;
    logic [LEN_WIDTH:0]      len_round;
    logic [LEN_WIDTH-1:0]    chunks_d;

    logic [MAX_MACS-1:0]                  lane_mask;
    logic [MAC_BIT_PER_GROUP-1:0]         g0_cnt, g1_cnt;
    logic [MAX_MACS-1:0][DATA_WIDTH-1:0]  rd_data_l, rd_weight_l, mac_data_l, mac_weight_l;
    logic                                 unused_mac_out;

    assign len_round   = {1'b0, vec_len} + (LEN_WIDTH+1)'(MAX_MACS - 1);
    assign chunks_d    = LEN_WIDTH'(len_round >> LANE_SHIFT);
    assign accept      = start && (state_q == ST_IDLE);
    // Only results that line up with one of our own issue beats count; this
    // drops pulses left in the MAC array by a job abandoned through reset.
    assign res_take    = mac_valid_out && vld_pipe[STAGES] &&
                         ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign last_issue  = (issue_cnt_q == chunks_q - ONE);
    assign last_result = (res_cnt_q == chunks_q - ONE);

    assign busy      = (state_q != ST_IDLE);
    assign rd_addr   = rd_en ? base_q + ADDR_WIDTH'(issue_cnt_q) : '0;
    assign res_data  = (state_q == ST_DONE) ? acc_q : '0;
    assign unused_mac_out = ^mac_out[MAX_GROUPS*RW-1:2*RW];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = (vec_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                rd_en = 1'b1;
                if (last_issue) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (res_take && last_result) state_d = ST_DONE;
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Job registers, issue/return counters, issue pipeline and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            chunks_q    <= '0;
            issue_cnt_q <= '0;
            res_cnt_q   <= '0;
            issue_rem_q <= '0;
            mac_rem_q   <= '0;
            acc_q       <= '0;
            vld_pipe    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], rd_en};
            if (accept) begin
                base_q      <= base_addr;
                chunks_q    <= chunks_d;
                issue_rem_q <= vec_len;
                issue_cnt_q <= '0;
                res_cnt_q   <= '0;
                acc_q       <= '0;
            end
            if (rd_en) begin
                issue_cnt_q <= issue_cnt_q + ONE;
                issue_rem_q <= issue_rem_q - CHUNK_ELEMS;
                mac_rem_q   <= issue_rem_q;
            end
            if (res_take) begin
                acc_q     <= acc_q + $signed(mac_out[RW-1:0]) + $signed(mac_out[2*RW-1:RW]);
                res_cnt_q <= res_cnt_q + ONE;
            end
        end
    end

    lane_mask_gen #(
        .MAX_MACS          (MAX_MACS),
        .LEN_WIDTH         (LEN_WIDTH),
        .MAC_BIT_PER_GROUP (MAC_BIT_PER_GROUP),
        .GROUP_LANES       (NPU_GROUP_LANES)
    ) u_lane_mask (
        .rem       (mac_rem_q),
        .lane_mask (lane_mask),
        .g0_cnt    (g0_cnt),
        .g1_cnt    (g1_cnt)
    );

    // Read data arrives the cycle after rd_en, so operands pass straight
    // through to the MAC array, gated by the issue beat and the lane mask.
    assign rd_data_l   = rd_data;
    assign rd_weight_l = rd_weight;
    for (genvar i = 0; i < MAX_MACS; i++) begin : g_mac_lane
        assign mac_data_l[i]   = (vld_pipe[0] && lane_mask[i]) ? rd_data_l[i]   : '0;
        assign mac_weight_l[i] = (vld_pipe[0] && lane_mask[i]) ? rd_weight_l[i] : '0;
    end
    assign mac_data     = mac_data_l;
    assign mac_weight   = mac_weight_l;
    assign mac_valid_in = vld_pipe[0];
    assign mac_num_groups = vld_pipe[0] ? 4'(NPU_GROUPS_USED) : 4'd0;

    // Group lane counts; groups 2 and up stay zero.
    always_comb begin
        mac_num_macs = '0;
        if (vld_pipe[0]) begin
            mac_num_macs[MAC_BIT_PER_GROUP-1:0]                   = g0_cnt;
            mac_num_macs[2*MAC_BIT_PER_GROUP-1:MAC_BIT_PER_GROUP] = g1_cnt;
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: operand-buffer and MAC-array models,
// spec-table jobs, random jobs against a plain-arithmetic dot-product model,
// and a reset-in-drain sequence with stale MAC results still in flight.
module tb_dot_product_sequencer;

    localparam int MM = 64, DW = 8, NG = 8, MB = 6, LW = 16, AW = 10;
    localparam int VW = MM * DW;
    localparam int DEPTH = 1 << AW;
    localparam int BUDGET = 2000;

    logic clk, rst, start, busy, rd_en, mac_valid_in, mac_valid_out, res_valid, res_ready;
    logic [LW-1:0]      vec_len;
    logic [AW-1:0]      base_addr, rd_addr;
    logic [VW-1:0]      rd_data, rd_weight, mac_data, mac_weight;
    logic [3:0]         mac_num_groups;
    logic [NG*MB-1:0]   mac_num_macs;
    logic [NG*32-1:0]   mac_out;
    logic signed [31:0] res_data;

    logic [VW-1:0] mem_d [DEPTH];
    logic [VW-1:0] mem_w [DEPTH];
    logic          s1_v;
    logic [NG*32-1:0] s1_out;

    int n_vec = 0;
    int n_bad = 0;

    dot_product_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .base_addr(base_addr),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_weight(rd_weight),
        .mac_valid_in(mac_valid_in), .mac_num_groups(mac_num_groups), .mac_num_macs(mac_num_macs),
        .mac_data(mac_data), .mac_weight(mac_weight), .mac_out(mac_out),
        .mac_valid_out(mac_valid_out), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data   <= mem_d[rd_addr];
            rd_weight <= mem_w[rd_addr];
        end
    end

    function automatic logic [31:0] grp_sum(input logic [VW-1:0] d, input logic [VW-1:0] w, input int g);
        int s = 0;
        for (int l = 0; l < 32; l++)
            s += int'($signed(d[(g*32+l)*DW +: DW])) * int'($signed(w[(g*32+l)*DW +: DW]));
        return 32'(s);
    endfunction

    // MAC array: sums each 32-lane group, result two cycles after the beat.
    // Not reset, so an abandoned job leaves pulses in flight. Upper groups carry junk.
    always @(posedge clk) begin
        s1_v   <= mac_valid_in;
        s1_out <= {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                   grp_sum(mac_data, mac_weight, 1), grp_sum(mac_data, mac_weight, 0)};
        mac_valid_out <= s1_v;
        mac_out       <= s1_out;
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: element j lives at buffer row base + j/64 (wrapping), lane j%64.
    function automatic int ref_dot(input int len, input int base);
        int acc = 0;
        for (int j = 0; j < len; j++) begin
            int a = (base + j / MM) % DEPTH;
            int l = j % MM;
            acc += int'($signed(mem_d[a][l*DW +: DW])) * int'($signed(mem_w[a][l*DW +: DW]));
        end
        return acc;
    endfunction

    function automatic logic [VW-1:0] ref_lanes(input bit wt, input int len, input int base, input int chunk);
        logic [VW-1:0] v = '0;
        int a = (base + chunk) % DEPTH;
        for (int l = 0; l < MM; l++)
            if (chunk * MM + l < len) v[l*DW +: DW] = wt ? mem_w[a][l*DW +: DW] : mem_d[a][l*DW +: DW];
        return v;
    endfunction

    function automatic logic [31:0] ref_nm(input int len, input int chunk);
        int rem = len - chunk * MM;
        int g0 = (rem < 32) ? rem : 32;
        int g1 = ((rem - g0) < 32) ? (rem - g0) : 32;
        logic [31:0] v = '0;
        v[MB-1:0]    = MB'(g0);
        v[2*MB-1:MB] = MB'(g1);
        return v;
    endfunction

    task automatic fill_const(input int len, input int base, input int d, input int w);
        for (int c = 0; c < (len + MM - 1) / MM; c++)
            for (int l = 0; l < MM; l++) begin
                mem_d[(base + c) % DEPTH][l*DW +: DW] = DW'(d);
                mem_w[(base + c) % DEPTH][l*DW +: DW] = DW'(w);
            end
    endtask

    task automatic fill_rand(input int len, input int base);
        for (int c = 0; c < (len + MM - 1) / MM; c++)
            for (int l = 0; l < MM; l++) begin
                mem_d[(base + c) % DEPTH][l*DW +: DW] = DW'($urandom());
                mem_w[(base + c) % DEPTH][l*DW +: DW] = DW'($urandom());
            end
    endtask

    // Runs one job from a low clock phase. mid>0 pulses start in that cycle;
    // abort>0 resets the DUT in that cycle and returns early.
    task automatic run_job(input string tag, input int len, input int base, input int hold,
                           input int mid, input int abort, input int exp_res);
        int c_exp = (len + MM - 1) / MM;
        int cyc = 1, nrd = 0, nmac = 0;
        bit got = 0, extra_busy = 0;
        vec_len = LW'(len); base_addr = AW'(base); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (1) begin
            if (abort > 0 && cyc == abort) begin
                rst = 1'b1;
                #1;
                chk32({tag, " rst ctrl"}, {busy, rd_en, mac_valid_in, res_valid, mac_num_groups}, 0);
                chk32({tag, " rst addr/res"}, {rd_addr, 22'd0} | res_data, 0);
                chkw({tag, " rst num_macs"}, mac_num_macs, '0);
                chkw({tag, " rst mac_data"}, mac_data, '0);
                chkw({tag, " rst mac_weight"}, mac_weight, '0);
                #1 rst = 1'b0;
                return;
            end
            if (rd_en) begin
                chk32({tag, " rd_addr"}, rd_addr, 32'((base + nrd) % DEPTH));
                nrd++;
            end
            if (mac_valid_in) begin
                chkw({tag, " mac_data"}, mac_data, ref_lanes(0, len, base, nmac));
                chkw({tag, " mac_weight"}, mac_weight, ref_lanes(1, len, base, nmac));
                chk32({tag, " num_macs"}, 32'(mac_num_macs), ref_nm(len, nmac));
                chk32({tag, " num_groups"}, mac_num_groups, 2);
                nmac++;
            end
            if (res_valid) begin got = 1; break; end
            if (cyc >= BUDGET) break;
            if (cyc == mid) begin start = 1'b1; vec_len = LW'(5); end
            else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk32({tag, " res_valid seen"}, 32'(got), 1);
        chk32({tag, " latency"}, cyc, (c_exp == 0) ? 1 : c_exp + 4);
        chk32({tag, " rd_en count"}, nrd, c_exp);
        chk32({tag, " mac beat count"}, nmac, c_exp);
        chk32({tag, " res_data"}, res_data, exp_res);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk32({tag, " held res_valid"}, 32'(res_valid), 1);
            chk32({tag, " held res_data"}, res_data, exp_res);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk32({tag, " idle after xfer"}, {res_valid, busy}, 0);
        if (mid > 0) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (busy || res_valid) extra_busy = 1;
            end
            chk32({tag, " no second job"}, 32'(extra_busy), 0);
        end
    endtask

    typedef struct {
        int len; int base; int d; int w; int hold; int mid; int exp_res;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{64,   10,   1,    1,    0, 0, 64};
        tbl[1] = '{100,  20,   2,    -3,   0, 0, -600};
        tbl[2] = '{0,    30,   7,    7,    0, 0, 0};
        tbl[3] = '{1,    40,   -128, -128, 5, 0, 16384};
        tbl[4] = '{256,  50,   1,    1,    0, 2, 256};
        tbl[5] = '{200,  1022, 3,    -1,   1, 0, -600};

        rst = 1'b1; start = 1'b0; res_ready = 1'b0; vec_len = '0; base_addr = '0;
        for (int a = 0; a < DEPTH; a++) begin
            mem_d[a] = {16{$urandom()}};
            mem_w[a] = {16{$urandom()}};
        end
        repeat (3) @(negedge clk);
        chk32("reset ctrl", {busy, rd_en, mac_valid_in, res_valid, mac_num_groups}, 0);
        chk32("reset res_data", res_data, 0);
        chkw("reset num_macs", mac_num_macs, '0);
        chkw("reset mac_data", mac_data, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            fill_const(tbl[i].len, tbl[i].base, tbl[i].d, tbl[i].w);
            run_job($sformatf("tbl%0d", i), tbl[i].len, tbl[i].base, tbl[i].hold,
                    tbl[i].mid, 0, tbl[i].exp_res);
        end

        for (int i = 0; i < 10; i++) begin
            int len = $urandom_range(0, 400);
            int base = $urandom_range(0, DEPTH - 1);
            fill_rand(len, base);
            run_job($sformatf("rnd%0d", i), len, base, $urandom_range(0, 3), 0, 0, ref_dot(len, base));
        end

        // Reset in DRAIN (cycle C+2 of a 4-chunk job), then a fresh job at once.
        fill_rand(256, 600);
        run_job("abort", 256, 600, 0, 0, 6, 0);
        fill_rand(130, 700);
        run_job("post", 130, 700, 0, 0, 0, ref_dot(130, 700));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 SHALL have parameter MAX_MACS, 64, lanes per MAC-array beat.
REQ-002 SHALL have parameter DATA_WIDTH, 8, signed operand width.
REQ-003 SHALL have parameter MAC_BIT_PER_GROUP, 6, per-group lane-count field width.
REQ-004 SHALL have parameter MAX_GROUPS, 8, group fields in num_macs bus.
REQ-005 SHALL have parameter LEN_WIDTH, 16, vector-length width.
REQ-006 SHALL have parameter ADDR_WIDTH, 10, operand-buffer address width.
REQ-007 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have ports start (in 1), vec_len (in LEN_WIDTH), base_addr (in ADDR_WIDTH): job request; busy (out 1) high outside IDLE.
REQ-010 SHALL have ports rd_en (out 1), rd_addr (out ADDR_WIDTH), rd_data (in MAX_MACS*DATA_WIDTH), rd_weight (in MAX_MACS*DATA_WIDTH): operand buffer, fixed 1-cycle read latency.
REQ-011 SHALL have ports mac_valid_in (out 1), mac_num_groups (out 4), mac_num_macs (out MAX_GROUPS*MAC_BIT_PER_GROUP), mac_data and mac_weight (out MAX_MACS*DATA_WIDTH): MAC-array drive.
REQ-012 SHALL have ports mac_out (in MAX_GROUPS*32), mac_valid_out (in 1): MAC-array result, 2 cycles after mac_valid_in.
REQ-013 SHALL have ports res_data (out 32 signed), res_valid (out 1), res_ready (in 1): result handshake.

Function
REQ-014 SHALL run FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-015 SHALL accept start only in IDLE; start in any other state is ignored, no latching.
REQ-016 SHALL on accept latch vec_len, base_addr, set chunks C = ceil(vec_len/64), clear accumulator and counters.
REQ-017 SHALL on accept with vec_len=0 go directly to DONE, res_data=0, no rd_en and no mac_valid_in.
REQ-018 SHALL in RUN assert rd_en one cycle per chunk, rd_addr = base_addr + chunk index, C consecutive cycles, then enter DRAIN; rd_addr wraps modulo 2^ADDR_WIDTH.
REQ-019 SHALL assert mac_valid_in exactly one cycle after each rd_en, with mac_data/mac_weight from rd_data/rd_weight of that read.
REQ-020 SHALL split each chunk into two groups: mac_num_groups=2; group0 lanes 0-31, group1 lanes 32-63; rem = remaining elements; g0 = min(32, rem), g1 = min(32, rem-g0); fields 2..7 of mac_num_macs zero.
REQ-021 SHALL zero mac_data and mac_weight lanes at index >= rem in the last chunk.
REQ-022 SHALL on each mac_valid_out add mac_out[31:0] + mac_out[63:32] into a 32-bit signed accumulator, two's-complement wrap, no saturation.
REQ-023 SHALL count returned results; DRAIN -> DONE in the cycle after the C-th mac_valid_out.
REQ-024 SHALL in DONE drive res_valid=1 and res_data=accumulator, stable until res_ready=1; transfer cycle returns to IDLE.
REQ-025 SHALL sustain one chunk per cycle; latency from accepted start (cycle 0) to res_valid = C+4 cycles.
REQ-026 SHALL ignore mac_valid_out in IDLE and DONE.
REQ-027 SHALL drive mac_valid_in, rd_en low whenever not issuing; operand/addr outputs are don't-care while their valid is low.

Reset
REQ-028 SHALL on rst force IDLE asynchronously, including mid-RUN/DRAIN, abandoning in-flight results.
REQ-029 SHALL reset busy, rd_en, rd_addr, mac_valid_in, mac_num_groups, mac_num_macs, mac_data, mac_weight, res_valid, res_data, accumulator, counters to 0.
REQ-030 SHALL discard mac_valid_out pulses arriving after reset release until next accepted start.

Structure
REQ-031 SHALL place MAX_MACS, DATA_WIDTH, MAX_GROUPS, MAC_BIT_PER_GROUP, group lane size (32) and FSM state encoding in the shared NPU package.
REQ-032 SHALL be one module; lane-mask generator may be a sub-module named lane_mask_gen.

Verification
REQ-033 SHALL cover vec_len=64, all data=1, weight=1 -> one chunk, g0=g1=32, res_data=64 at cycle 5.
REQ-034 SHALL cover vec_len=100, data=2, weight=-3 -> chunk 2 g0=32, g1=4, lanes 36-63 zeroed, res_data=-600 at cycle 6.
REQ-035 SHALL cover vec_len=0 -> no rd_en/mac_valid_in, res_valid with res_data=0 next cycle.
REQ-036 SHALL cover vec_len=1, data=-128, weight=-128 -> res_data=16384; res_ready low 5 cycles -> res_valid/res_data held.
REQ-037 SHALL cover start pulsed during RUN of a 256-element job -> ignored, single result, rd_addr base..base+3.
REQ-038 SHALL cover rst asserted in DRAIN -> all outputs 0 immediately, subsequent job result unaffected by stale mac_valid_out.
